output_unit_vc: RTL
===================

Name: output_unit_vc

Overview:
- Parametrised next-generation router output port, replacing the single-channel output FSM.
- Arbitrates flits from NUM_PORTS switch inputs onto one downstream link carrying NUM_VCS virtual channels.
- Wormhole packet locking per VC, credit-based downstream flow control, and a registered output stage.
- Sits between the crossbar (switch traversal) and the inter-router link.

Parameters:
- NUM_PORTS, 5, number of input ports that can request this output
- NUM_VCS, 2, virtual channels on the downstream link
- FLIT_W, 34, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type (10 head, 00 body, 01 tail, 11 head+tail)
- CREDITS, 4, downstream buffer depth per VC (initial credit count)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  NUM_PORTS  per-port flit valid from the switch
- i_req_vc  in  NUM_PORTS*VCW  target VC per port, VCW=max(1,$clog2(NUM_VCS))
- i_flit  in  NUM_PORTS*FLIT_W  flit per port
- o_grant  out  NUM_PORTS  one-hot, combinational; flit accepted this cycle
- o_valid  out  1  downstream flit valid (registered)
- o_vc  out  VCW  downstream VC (registered)
- o_flit  out  FLIT_W  downstream flit (registered)
- i_credit_valid  in  1  downstream returns one credit
- i_credit_vc  in  VCW  VC of the returned credit
- o_vc_busy  out  NUM_VCS  VC locked to a packet
- o_err  out  1  sticky error flag

Behaviour:
- Reset (synchronous, active-high):
  - o_valid=0, o_vc=0, o_flit=0, o_err=0.
  - All VCs IDLE (o_vc_busy=0), credits[v]=CREDITS, RR pointer=0.
- Per-VC FSM, two states:
  - IDLE: accepts only head or head+tail flits.
  - ACTIVE(owner): accepts only body/tail flits from the owner port.
- Eligibility of port p (target VC v) requires all of:
  - i_req[p]=1;
  - credits[v]>0;
  - v IDLE and flit is head/head+tail, or v ACTIVE with owner==p and flit is body/tail.
- Arbitration:
  - Round-robin over eligible ports, starting at the RR pointer.
  - At most one grant per cycle; o_grant is combinational in the same cycle.
  - On a grant to port g, the pointer becomes (g+1) mod NUM_PORTS next cycle; with no grant it holds.
- Transfer on a grant in cycle N:
  - o_valid=1, o_flit, o_vc appear in cycle N+1.
  - No grant → o_valid=0 in N+1; o_flit/o_vc hold their last value.
- FSM transitions on a granted flit:
  - head: IDLE→ACTIVE(owner=g).
  - tail: ACTIVE→IDLE.
  - head+tail: stays IDLE.
  - body: no change.
- Credits:
  - Granted flit decrements credits[v].
  - i_credit_valid increments credits[i_credit_vc].
  - Both on the same VC in the same cycle → net unchanged.
  - A credit return that would exceed CREDITS saturates at CREDITS and sets o_err.
- Ineligible requests are not errors; they stay ungranted.
- A body/tail flit arriving at an IDLE VC, or from a non-owner port, is never granted.
- Different VCs interleave flit-by-flit on the link.
- Counter width is $clog2(CREDITS+1).
- o_err clears only on reset.

Optional Feature:
- Macro: OUTPUT_UNIT_STATS_EN.
- When defined:
  - Adds outputs o_flit_cnt (32b) and o_stall_cnt (32b).
  - o_flit_cnt increments on every grant.
  - o_stall_cnt increments in every cycle with any i_req set and no grant.
  - Both wrap at 2^32 and reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single-flit packet (type 11) on port 2, VC1 → o_grant=00100 same cycle; next cycle o_valid=1, o_vc=1; credits[1]=3; VC1 stays IDLE.
- Ports 0 and 3 both send head to VC0, pointer=0 → port 0 granted, VC0 owner=0; port 3 blocked until port 0's tail is granted; then port 3's head is granted.
- 4 flits to VC0 (CREDITS=4) with no credit return → 4 grants, then the 5th request is held ungranted; one i_credit_valid on VC0 → granted the next cycle.
- Credit return and grant on the same VC in the same cycle → counter unchanged; extra credit at CREDITS → stays 4, o_err=1 and remains 1.
- Ports 1 (VC0) and 4 (VC1) streaming packets → flits alternate 1,4,1,4; o_vc alternates 0,1.
- Reset asserted mid-packet (VC0 ACTIVE, credits=2) → next cycle VC0 IDLE, credits=4, o_valid=0; a body flit is then not granted.

Source files
------------

// File: rtl/output_unit_vc_if.sv
// Output-port bus: switch-side requests/grants, downstream flit link and credit return.
// Statistics counters are present only when OUTPUT_UNIT_STATS_EN is defined.
interface output_unit_vc_if #(
  parameter int NUM_PORTS = 5,
  parameter int NUM_VCS   = 2,
  parameter int FLIT_W    = 34
);
  localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  logic [NUM_PORTS-1:0]        i_req;
  logic [NUM_PORTS*VCW-1:0]    i_req_vc;
  logic [NUM_PORTS*FLIT_W-1:0] i_flit;
  logic [NUM_PORTS-1:0]        o_grant;
  logic                        o_valid;
  logic [VCW-1:0]              o_vc;
  logic [FLIT_W-1:0]           o_flit;
  logic                        i_credit_valid;
  logic [VCW-1:0]              i_credit_vc;
  logic [NUM_VCS-1:0]          o_vc_busy;
  logic                        o_err;
`ifdef OUTPUT_UNIT_STATS_EN
  logic [31:0]                 o_flit_cnt;
  logic [31:0]                 o_stall_cnt;
`endif

  modport slave (
`ifdef OUTPUT_UNIT_STATS_EN
    output o_flit_cnt, o_stall_cnt,
`endif
    input  i_req, i_req_vc, i_flit, i_credit_valid, i_credit_vc,
    output o_grant, o_valid, o_vc, o_flit, o_vc_busy, o_err
  );

  modport master (
`ifdef OUTPUT_UNIT_STATS_EN
    input  o_flit_cnt, o_stall_cnt,
`endif
    output i_req, i_req_vc, i_flit, i_credit_valid, i_credit_vc,
    input  o_grant, o_valid, o_vc, o_flit, o_vc_busy, o_err
  );
endinterface

// File: rtl/output_unit_vc.sv
// Router output port: round-robin switch arbitration, per-VC wormhole locking, credit flow control.
// Define OUTPUT_UNIT_STATS_EN to add the flit/stall statistics counters.
module output_unit_vc #(
  parameter int NUM_PORTS = 5,
  parameter int NUM_VCS   = 2,
  parameter int FLIT_W    = 34,
  parameter int CREDITS   = 4
) (
  input logic             clk,
  input logic             reset,
  output_unit_vc_if.slave bus
);
  localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW  = $clog2(CREDITS + 1);
  localparam logic [1:0] FT_TAIL = 2'b01;
  localparam logic [1:0] FT_HEAD = 2'b10;

  typedef enum logic {VC_IDLE, VC_ACTIVE} vc_state_e;

  vc_state_e         state_q   [NUM_VCS];
  vc_state_e         state_d   [NUM_VCS];
  logic [PW-1:0]     owner_q   [NUM_VCS];
  logic [PW-1:0]     owner_d   [NUM_VCS];
  logic [CW-1:0]     credits_q [NUM_VCS];
  logic [CW-1:0]     credits_d [NUM_VCS];
  logic [PW-1:0]     rr_q, rr_d;
  logic              valid_q, valid_d;
  logic [VCW-1:0]    vc_q, vc_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              err_q, err_d;

  logic [VCW-1:0]       port_vc   [NUM_PORTS];
  logic [1:0]           port_type [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig;
  logic                 any_grant;
  logic [PW-1:0]        gnt_idx;
  logic [VCW-1:0]       g_vc;
  logic [1:0]           g_type;
  logic [FLIT_W-1:0]    g_flit;
  logic [NUM_VCS-1:0]   ret_hit;
  logic [NUM_VCS-1:0]   busy;
  int                   scan;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign port_vc[p]   = bus.i_req_vc[p*VCW +: VCW];
    assign port_type[p] = bus.i_flit[p*FLIT_W + FLIT_W - 2 +: 2];
  end

  // Heads may only open an idle VC; body/tail may only continue the owner's packet.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.i_req[p] && (int'(port_vc[p]) < NUM_VCS) && (credits_q[port_vc[p]] != '0)) begin
        if (state_q[port_vc[p]] == VC_IDLE) elig[p] = port_type[p][1];
        else elig[p] = !port_type[p][1] && (owner_q[port_vc[p]] == PW'(p));
      end
    end
  end

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    any_grant = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = int'(rr_q) + i;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      if (!any_grant && elig[PW'(scan)]) begin
        any_grant = 1'b1;
        gnt_idx   = PW'(scan);
      end
    end
  end

  assign g_vc    = port_vc[gnt_idx];
  assign g_type  = port_type[gnt_idx];
  assign g_flit  = bus.i_flit[gnt_idx*FLIT_W +: FLIT_W];
  assign ret_hit = bus.i_credit_valid ? (NUM_VCS'(1) << bus.i_credit_vc) : '0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    credits_d = credits_q;
    err_d     = err_q;
    rr_d      = rr_q;
    valid_d   = any_grant;
    vc_d      = vc_q;
    flit_d    = flit_q;
    if (any_grant) begin
      vc_d   = g_vc;
      flit_d = g_flit;
      rr_d   = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end
    for (int v = 0; v < NUM_VCS; v++) begin
      if (any_grant && (g_vc == VCW'(v))) begin
        case (g_type)
          FT_HEAD: begin
            state_d[v] = VC_ACTIVE;
            owner_d[v] = gnt_idx;
          end
          FT_TAIL: state_d[v] = VC_IDLE;
          default: ;
        endcase
        // A simultaneous return on the same VC cancels the spend.
        if (!ret_hit[v]) credits_d[v] = credits_q[v] - 1'b1;
      end else if (ret_hit[v]) begin
        if (credits_q[v] == CW'(CREDITS)) err_d = 1'b1;
        else credits_d[v] = credits_q[v] + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-VC arrays are control state, not storage, so every entry is reset.
      for (int v = 0; v < NUM_VCS; v++) begin
        state_q[v]   <= VC_IDLE;
        owner_q[v]   <= '0;
        credits_q[v] <= CW'(CREDITS);
      end
      rr_q    <= '0;
      valid_q <= 1'b0;
      vc_q    <= '0;
      flit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      vc_q      <= vc_d;
      flit_q    <= flit_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int v = 0; v < NUM_VCS; v++) busy[v] = (state_q[v] == VC_ACTIVE);
  end

  assign bus.o_grant   = any_grant ? (NUM_PORTS'(1) << gnt_idx) : '0;
  assign bus.o_valid   = valid_q;
  assign bus.o_vc      = vc_q;
  assign bus.o_flit    = flit_q;
  assign bus.o_vc_busy = busy;
  assign bus.o_err     = err_q;

`ifdef OUTPUT_UNIT_STATS_EN
  logic [31:0] flit_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (any_grant) flit_cnt_q <= flit_cnt_q + 32'd1;
      if ((|bus.i_req) && !any_grant) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.o_flit_cnt  = flit_cnt_q;
  assign bus.o_stall_cnt = stall_cnt_q;
`endif
endmodule
